// File: rtl/fir_result_reader.sv
// Rounds finished FIR accumulator words to the sample width and buffers them in a
// small FIFO feeding a valid/ready stream. Define FIR_READER_SAT_EN to clamp positive rounding overflow.
module fir_result_reader #(
  parameter int inWidth  = 20,
  parameter int outWidth = 16,
  parameter int depth    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     firValid,
  input  logic [inWidth-1:0]       FIR_output,
  output logic [outWidth-1:0]      outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     full,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow,
  input  logic                     clrOvf
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam int SH = inWidth - outWidth - 1;
  localparam logic signed [inWidth-1:0] HALF = inWidth'(1) << SH;
`ifdef FIR_READER_SAT_EN
  localparam logic signed [inWidth-1:0] MAXIN  = {1'b0, {(inWidth-1){1'b1}}};
  // Smallest input whose rounded sum no longer fits the positive range.
  localparam logic signed [inWidth-1:0] OVF_AT = MAXIN - HALF + inWidth'(1);
`endif

  function automatic logic signed [outWidth-1:0] round_word(input logic signed [inWidth-1:0] x);
`ifdef FIR_READER_SAT_EN
    if (x >= OVF_AT)
      round_word = {1'b0, {(outWidth-1){1'b1}}};
    else
      round_word = outWidth'((x + HALF) >>> (inWidth - outWidth));
`else
    round_word = outWidth'((x + HALF) >>> (inWidth - outWidth));
`endif
  endfunction

  logic signed [outWidth-1:0] mem [depth];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic signed [outWidth-1:0] wr_word_p0;
  logic                       vld_p0;
  logic                       pop;
  logic                       drop;

  // Stage p0: round the incoming result and decide whether it enters the FIFO.
  always_comb begin
    wr_word_p0 = round_word($signed(FIR_output));
    pop        = outValid & outReady;
    vld_p0     = firValid & (~full | pop);
    drop       = firValid & full & ~pop;
  end

  // Stage p1: FIFO storage; data words carry no reset, occupancy is tracked by control.
  always_ff @(posedge clk) begin
    if (vld_p0)
      mem[wr_ptr] <= wr_word_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (vld_p0)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (vld_p0 && !pop)
        count <= count + CW'(1);
      else if (!vld_p0 && pop)
        count <= count - CW'(1);
      if (drop)
        overflow <= 1'b1;
      else if (clrOvf)
        overflow <= 1'b0;
    end
  end

  always_comb begin
    outValid = (count != '0);
    full     = (count == CW'(depth));
    outData  = outValid ? mem[rd_ptr] : '0;
  end

endmodule
